// File: rtl/titan_pkg.sv
// Shared branch-op encodings, default datapath width and the outcome decode
// used by the branch unit and by the front-end decoder.
package titan_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_BLT  = 3'd3,
        OP_BGE  = 3'd4,
        OP_BLTU = 3'd5,
        OP_BGEU = 3'd6,
        OP_RSVD = 3'd7
    } br_op_e;

    // NOP and the reserved encoding never take.
    function automatic logic br_taken(input logic [2:0] op, input logic eq,
                                      input logic lt, input logic ltu);
        logic t;
        t = 1'b0;
        case (op)
            OP_BEQ:  t = eq;
            OP_BNE:  t = !eq;
            OP_BLT:  t = lt;
            OP_BGE:  t = !lt;
            OP_BLTU: t = ltu;
            OP_BGEU: t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/titan_branch_unit_if.sv
// Request/result bundle of the branch unit. Handshake: a beat moves on a
// rising edge where valid && ready; the sender holds payload stable while valid && !ready.
interface titan_branch_unit_if
    import titan_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_mispredict;
    logic [XLEN-1:0] out_redirect;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_pc, in_imm, in_pred, out_ready,
        input  in_ready, out_valid, out_taken, out_mispredict, out_redirect
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_pc, in_imm, in_pred, out_ready,
        output in_ready, out_valid, out_taken, out_mispredict, out_redirect
    );
endinterface

// File: rtl/titan_branch_cmp.sv
// Combinational operand comparator: equality, signed and unsigned less-than.
module titan_branch_cmp #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_eq,
    output logic            o_lt,
    output logic            o_ltu
);
    assign o_eq  = (i_a == i_b);
    assign o_lt  = ($signed(i_a) < $signed(i_b));
    assign o_ltu = (i_a < i_b);
endmodule

// File: rtl/titan_branch_unit.sv
// Elastic branch-resolution pipeline: compares operands, decides taken,
// flags mispredicts and produces the corrected next PC.
module titan_branch_unit
    import titan_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned STAGES = 2
) (
    input logic                clk,
    input logic                rst_n,
    input logic                flush,
    titan_branch_unit_if.slave bus
);
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_seq;

    titan_branch_cmp #(.XLEN(XLEN)) u_cmp (
        .i_a   (bus.in_rs1),
        .i_b   (bus.in_rs2),
        .o_eq  (w_eq),
        .o_lt  (w_lt),
        .o_ltu (w_ltu)
    );

    // Both candidate next PCs wrap modulo 2^XLEN.
    assign w_tgt = bus.in_pc + bus.in_imm;
    assign w_seq = bus.in_pc + XLEN'(4);

    if (STAGES == 1) begin : g_one
        logic            r_valid;
        logic            r_taken;
        logic            r_mis;
        logic [XLEN-1:0] r_redirect;
        logic            w_en;
        logic            w_taken;

        assign w_en    = !r_valid || bus.out_ready;
        assign w_taken = br_taken(bus.in_op, w_eq, w_lt, w_ltu);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid    <= 1'b0;
                r_taken    <= 1'b0;
                r_mis      <= 1'b0;
                r_redirect <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (w_en) begin
                r_valid    <= bus.in_valid;
                r_taken    <= w_taken;
                r_mis      <= w_taken ^ bus.in_pred;
                r_redirect <= w_taken ? w_tgt : w_seq;
            end
        end

        assign bus.in_ready       = w_en && !flush;
        assign bus.out_valid      = r_valid;
        assign bus.out_taken      = r_taken;
        assign bus.out_mispredict = r_mis;
        assign bus.out_redirect   = r_redirect;
    end else begin : g_two
        logic            r_s1_valid;
        logic [2:0]      r_s1_op;
        logic            r_s1_pred;
        logic [XLEN-1:0] r_s1_tgt;
        logic [XLEN-1:0] r_s1_seq;
        logic            r_s1_eq;
        logic            r_s1_lt;
        logic            r_s1_ltu;
        logic            r_s2_valid;
        logic            r_s2_taken;
        logic            r_s2_mis;
        logic [XLEN-1:0] r_s2_redirect;
        logic            w_s1_en;
        logic            w_s2_en;
        logic            w_s1_taken;

        // A stage loads when empty or when its successor drains this cycle.
        assign w_s2_en    = !r_s2_valid || bus.out_ready;
        assign w_s1_en    = !r_s1_valid || w_s2_en;
        assign w_s1_taken = br_taken(r_s1_op, r_s1_eq, r_s1_lt, r_s1_ltu);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_valid <= 1'b0;
                r_s1_op    <= '0;
                r_s1_pred  <= 1'b0;
                r_s1_tgt   <= '0;
                r_s1_seq   <= '0;
                r_s1_eq    <= 1'b0;
                r_s1_lt    <= 1'b0;
                r_s1_ltu   <= 1'b0;
            end else if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_en) begin
                r_s1_valid <= bus.in_valid;
                r_s1_op    <= bus.in_op;
                r_s1_pred  <= bus.in_pred;
                r_s1_tgt   <= w_tgt;
                r_s1_seq   <= w_seq;
                r_s1_eq    <= w_eq;
                r_s1_lt    <= w_lt;
                r_s1_ltu   <= w_ltu;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_valid    <= 1'b0;
                r_s2_taken    <= 1'b0;
                r_s2_mis      <= 1'b0;
                r_s2_redirect <= '0;
            end else if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_en) begin
                r_s2_valid    <= r_s1_valid;
                r_s2_taken    <= w_s1_taken;
                r_s2_mis      <= w_s1_taken ^ r_s1_pred;
                r_s2_redirect <= w_s1_taken ? r_s1_tgt : r_s1_seq;
            end
        end

        assign bus.in_ready       = w_s1_en && !flush;
        assign bus.out_valid      = r_s2_valid;
        assign bus.out_taken      = r_s2_taken;
        assign bus.out_mispredict = r_s2_mis;
        assign bus.out_redirect   = r_s2_redirect;
    end
endmodule

// File: tb/tb_titan_branch_unit.sv
// Bench for titan_branch_unit (XLEN=32, STAGES=2): directed corner cases,
// back-pressure, flush, async reset and a random stream against a reference model.
module tb_titan_branch_unit;
  logic clk;
  logic rst_n;
  logic flush;
  logic bp_on;
  int   n_cmp;
  int   n_bad;
  logic [33:0] exp_q[$];

  titan_branch_unit_if #(.XLEN(32)) bus ();

  titan_branch_unit #(.XLEN(32), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] pc,
                                        input logic [31:0] imm, input logic pred);
    logic t;
    logic [31:0] nx;
    case (op)
      3'd1:    t = (a == b);
      3'd2:    t = (a != b);
      3'd3:    t = ($signed(a) < $signed(b));
      3'd4:    t = !($signed(a) < $signed(b));
      3'd5:    t = (a < b);
      3'd6:    t = (a >= b);
      default: t = 1'b0;
    endcase
    nx = t ? (pc + imm) : (pc + 32'd4);
    return {t, t ^ pred, nx};
  endfunction

  // Scoreboard: inputs and outputs sampled mid-cycle, i.e. what the next edge transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("taken", bus.out_taken, e[33]);
          chk("mispredict", bus.out_mispredict, e[32]);
          chk("redirect", bus.out_redirect, e[31:0]);
        end
      end
      if (flush) exp_q.delete();
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_pc, bus.in_imm, bus.in_pred));
    end
  end

  always @(posedge clk) begin
    if (bp_on) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                      output int tries);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_pc    = pc;
    bus.in_imm   = imm;
    bus.in_pred  = pred;
    tries = 0;
    do begin
      @(negedge clk);
      tries++;
      ok = bus.in_ready;
      sync();
    end while (!ok && tries < 100);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 300) begin
      sync();
      cyc++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tries;
    logic snap_v, snap_t, snap_m;
    logic [31:0] snap_r;
    n_cmp = 0;
    n_bad = 0;
    bp_on = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_pc     = '0;
    bus.in_imm    = '0;
    bus.in_pred   = 1'b0;
    bus.out_ready = 1'b1;

    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_taken", bus.out_taken, 0);
    chk("rst_out_mis", bus.out_mispredict, 0);
    chk("rst_out_redirect", bus.out_redirect, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    sync();

    // BLT -1 < 1 signed: taken, exact two-edge latency.
    send(3'd3, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, tries);
    idle();
    chk("lat_edge1_valid", bus.out_valid, 0);
    sync();
    chk("lat_edge2_valid", bus.out_valid, 1);
    chk("blt_taken", bus.out_taken, 1);
    chk("blt_mis", bus.out_mispredict, 1);
    chk("blt_redirect", bus.out_redirect, 32'h120);
    // BLTU same operands: not taken.
    send(3'd5, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, tries);
    idle();
    sync();
    chk("bltu_taken", bus.out_taken, 0);
    chk("bltu_mis", bus.out_mispredict, 0);
    chk("bltu_redirect", bus.out_redirect, 32'h104);
    // Wrapping targets.
    send(3'd1, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'd8, 1'b1, tries);
    idle();
    sync();
    chk("beq_wrap_redirect", bus.out_redirect, 32'h4);
    send(3'd1, 32'h55, 32'h56, 32'hFFFF_FFFC, 32'd8, 1'b1, tries);
    idle();
    sync();
    chk("beq_nt_redirect", bus.out_redirect, 32'h0);
    chk("beq_nt_mis", bus.out_mispredict, 1);
    drain();

    // Full throughput: every op, one accept per cycle.
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 32'(i * 3), 32'(7 - i), 32'h2000 + 32'(i * 4), 32'hFFFF_FFF0, 1'(i & 1), tries);
      chk("tput_tries", tries, 1);
    end
    idle();
    drain();

    // Back-pressure mid-stream.
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(3'd2, 32'(i), 32'd1, 32'h3000 + 32'(i * 16), 32'h40, 1'b0, tries);
        idle();
      end
      begin
        sync();
        sync();
        bus.out_ready = 1'b0;
        #1;
        snap_v = bus.out_valid;
        snap_t = bus.out_taken;
        snap_m = bus.out_mispredict;
        snap_r = bus.out_redirect;
        chk("stall_valid", snap_v, 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_hold_valid", bus.out_valid, snap_v);
          chk("stall_hold_taken", bus.out_taken, snap_t);
          chk("stall_hold_mis", bus.out_mispredict, snap_m);
          chk("stall_hold_redirect", bus.out_redirect, snap_r);
          chk("stall_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two entries in flight and a request offered.
    bus.out_ready = 1'b0;
    send(3'd1, 32'd9, 32'd9, 32'h4000, 32'h80, 1'b0, tries);
    send(3'd2, 32'd9, 32'd8, 32'h4004, 32'h80, 1'b0, tries);
    bus.in_op  = 3'd6;
    bus.in_pc  = 32'h4008;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 0);
    sync();
    flush = 1'b0;
    idle();
    chk("flush_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    repeat (6) sync();
    chk("flush_quiet", bus.out_valid, 0);
    chk("flush_q_empty", exp_q.size(), 0);

    // Random stream with random back-pressure.
    bp_on = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b, imm;
      a   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
      imm = 32'($signed(12'($urandom_range(0, 4095))));
      send(3'($urandom_range(0, 7)), a, b, $urandom & 32'hFFFF_FFFC, imm, 1'($urandom_range(0, 1)), tries);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        sync();
      end
    end
    idle();
    bp_on = 1'b0;
    #2;
    bus.out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    send(3'd4, 32'd5, 32'd3, 32'h5000, 32'h10, 1'b0, tries);
    send(3'd3, 32'd5, 32'd3, 32'h5004, 32'h10, 1'b1, tries);
    idle();
    chk("prereset_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (5) sync();
    chk("post_rst_quiet", bus.out_valid, 0);
    send(3'd6, 32'd3, 32'd5, 32'h6000, 32'h100, 1'b1, tries);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
